// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus bundle.
// Groups the display-side inputs (anode enables, segment lines, frame abort)
// with the recovered-frame outputs of seg_scan_decoder.
//   an_n        digit enables, active-low, one low bit per digit slot
//   seg_n       segment lines, active-low, bit6=g .. bit0=a
//   clear       synchronous frame abort
//   hex_out     last published frame, digit k at [4k+3:4k]
//   blank_mask  1 = digit k was blank in the last frame
//   frame_valid one-cycle pulse when hex_out/blank_mask update
//   err         sticky per-digit undecodable-pattern flags
// master: the side driving the display bus; slave: the decoder.
interface seg_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an_n;
    logic [6:0]          seg_n;
    logic                clear;
    logic [4*DIGITS-1:0] hex_out;
    logic [DIGITS-1:0]   blank_mask;
    logic                frame_valid;
    logic [DIGITS-1:0]   err;

    modport master (
        output an_n, seg_n, clear,
        input  hex_out, blank_mask, frame_valid, err
    );

    modport slave (
        input  an_n, seg_n, clear,
        output hex_out, blank_mask, frame_valid, err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder.
// Watches a multiplexed active-low display bus, debounces each digit slot,
// decodes the segment pattern back to a hex nibble and publishes a full
// frame once every slot has been captured.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_decoder_if.slave (an_n, seg_n, clear in;
//          hex_out, blank_mask, frame_valid, err out)
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | an_q not one-hot, waiting for a single selected digit
// S_SETTLE   | digit selected, counting stable cycles
// S_CAPTURE  | write decoded slot into shadow, mark it captured
// S_HOLD     | slot captured, ignore segment changes until an_q moves
module seg_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_decoder_if.slave    bus
);

    // rem counts down the SETTLE cycles still required after entry.
    localparam int CW = (SETTLE > 2) ? $clog2(SETTLE - 1) : 1;
    localparam logic [CW-1:0] REM_LOAD = (SETTLE > 2) ? CW'(SETTLE - 2) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    // With SETTLE=1 the entry cycle already satisfies the stability count.
    localparam state_t ENTRY = (SETTLE == 1) ? S_CAPTURE : S_SETTLE;

    state_t              state;
    logic [CW-1:0]       rem;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS-1:0]   an_prev;
    logic [DIGITS-1:0]   an_sel;
    logic [6:0]          seg_q;
    logic [6:0]          seg_prev;
    logic [4*DIGITS-1:0] shadow_hex;
    logic [DIGITS-1:0]   shadow_blank;
    logic [DIGITS-1:0]   cap_mask;
    logic [DIGITS-1:0]   err_q;
    logic [4*DIGITS-1:0] hex_out_q;
    logic [DIGITS-1:0]   blank_q;
    logic                fv_q;

    // Returns {invalid, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] d;
        case (s)
            7'b1000000: d = {2'b00, 4'h0};
            7'b1111001: d = {2'b00, 4'h1};
            7'b0100100: d = {2'b00, 4'h2};
            7'b0110000: d = {2'b00, 4'h3};
            7'b0011001: d = {2'b00, 4'h4};
            7'b0010010: d = {2'b00, 4'h5};
            7'b0000010: d = {2'b00, 4'h6};
            7'b1111000: d = {2'b00, 4'h7};
            7'b0000000: d = {2'b00, 4'h8};
            7'b0010000: d = {2'b00, 4'h9};
            7'b0001000: d = {2'b00, 4'hA};
            7'b0000011: d = {2'b00, 4'hB};
            7'b1000110: d = {2'b00, 4'hC};
            7'b0100001: d = {2'b00, 4'hD};
            7'b0000110: d = {2'b00, 4'hE};
            7'b0001110: d = {2'b00, 4'hF};
            7'b1111111: d = {2'b01, 4'h0};
            default:    d = {2'b10, 4'h0};
        endcase
        return d;
    endfunction

    function automatic logic one_low(input logic [DIGITS-1:0] a);
        int z;
        z = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!a[i]) z++;
        end
        return (z == 1);
    endfunction

    logic              stable;
    logic              an_onehot;
    logic              publish;
    logic              capture_fire;
    logic [5:0]        dec;
    logic [DIGITS-1:0] cap_bit;

    assign stable       = (an_q == an_prev) && (seg_q == seg_prev);
    assign an_onehot    = one_low(an_q);
    assign publish      = &cap_mask;
    // The capture cycle re-checks stability so the decoded pattern is the
    // one that settled, not the first value of the next digit.
    assign capture_fire = (state == S_CAPTURE) && stable;
    assign dec          = decode(seg_q);
    assign cap_bit      = ~an_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rem          <= '0;
            an_q         <= '1;
            an_prev      <= '1;
            an_sel       <= '1;
            seg_q        <= '1;
            seg_prev     <= '1;
            shadow_hex   <= '0;
            shadow_blank <= '0;
            cap_mask     <= '0;
            err_q        <= '0;
            hex_out_q    <= '0;
            blank_q      <= '0;
            fv_q         <= 1'b0;
        end else begin
            an_q     <= bus.an_n;
            seg_q    <= bus.seg_n;
            an_prev  <= an_q;
            seg_prev <= seg_q;
            fv_q     <= 1'b0;

            if (bus.clear) begin
                cap_mask <= '0;
                err_q    <= '0;
                state    <= S_IDLE;
            end else begin
                if (publish) begin
                    hex_out_q <= shadow_hex;
                    blank_q   <= shadow_blank;
                    fv_q      <= 1'b1;
                end
                cap_mask <= (publish ? '0 : cap_mask) | (capture_fire ? cap_bit : '0);
                if (capture_fire && dec[5]) begin
                    err_q <= err_q | cap_bit;
                end

                case (state)
                    S_IDLE: begin
                        if (an_onehot) begin
                            an_sel <= an_q;
                            rem    <= REM_LOAD;
                            state  <= ENTRY;
                        end
                    end
                    S_SETTLE: begin
                        if (!stable) begin
                            an_sel <= an_q;
                            rem    <= REM_LOAD;
                            state  <= an_onehot ? ENTRY : S_IDLE;
                        end else if (rem == '0) begin
                            state <= S_CAPTURE;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        if (stable) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                if (cap_bit[i]) begin
                                    shadow_hex[4*i +: 4] <= dec[3:0];
                                    shadow_blank[i]      <= dec[4];
                                end
                            end
                            state <= S_HOLD;
                        end else begin
                            an_sel <= an_q;
                            rem    <= REM_LOAD;
                            state  <= an_onehot ? ENTRY : S_IDLE;
                        end
                    end
                    S_HOLD: begin
                        if (an_q != an_sel) begin
                            an_sel <= an_q;
                            rem    <= REM_LOAD;
                            state  <= an_onehot ? ENTRY : S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.hex_out     = hex_out_q;
    assign bus.blank_mask  = blank_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Seven-segment scan decoder. It monitors a time-multiplexed, active-low seven-segment display bus (anode enables plus segment lines) and recovers the displayed hexadecimal value. Each digit slot is debounced, and its segment pattern is decoded back to a nibble. A full frame is published once every digit has been captured. It sits on the display side of the board as a self-check and readback block for the hex display path.

## Interface
- DIGITS, 4: number of multiplexed digits; legal range 1–8.
- SETTLE, 4: consecutive stable cycles required before a digit is sampled; minimum 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- an_n  in  DIGITS  digit enables, active-low; exactly one low bit selects a digit.
- seg_n  in  7  segment lines, active-low; bit6=g … bit0=a.
- clear  in  1  synchronous frame abort; clears the capture mask and err.
- hex_out  out  4*DIGITS  decoded frame; digit k occupies bits [4k+3:4k].
- blank_mask  out  DIGITS  1 = the digit displayed blank in the last frame.
- frame_valid  out  1  one-cycle pulse when hex_out and blank_mask update.
- err  out  DIGITS  sticky per-digit flag for an undecodable pattern; cleared by clear or reset.

## Operation
- Input stage: an_n and seg_n are registered once (an_q, seg_q). All decisions use the registered copies.
- Decode table (seg_n → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
  - 1111111 → blank: nibble 0, blank bit set.
  - Any other pattern → nibble 0, blank bit clear, err[k] set.
- FSM states:
  - IDLE: an_q is not exactly one-hot (all ones, or several lows). Stay in IDLE. When an_q becomes one-hot, load cnt=1 and go to SETTLE.
  - SETTLE: if an_q or seg_q differs from the previous cycle, go to IDLE (or restart cnt=1 if the new an_q is one-hot). Otherwise increment cnt. When cnt reaches SETTLE, go to CAPTURE.
  - CAPTURE: one cycle. Write the nibble and blank bit into shadow slot k, where k is the index of the low bit. Set cap_mask[k] and set err[k] if the pattern is invalid. Go to HOLD.
  - HOLD: stay while an_q is unchanged; seg changes here are ignored. On an an_q change, go to IDLE, or go directly to SETTLE with cnt=1 if the new value is one-hot.
- Frame publish: on the cycle after cap_mask becomes all ones:
  - copy the shadow registers to hex_out and blank_mask;
  - pulse frame_valid;
  - clear cap_mask.
- A slot captured again before the frame completes is overwritten; the latest capture wins.
- clear has priority over CAPTURE and publish in the same cycle. It clears cap_mask and err and sends the FSM to IDLE. hex_out and blank_mask are retained.
- Reset values: hex_out=0, blank_mask=0, frame_valid=0, err=0, cap_mask=0, shadow registers=0, FSM=IDLE.

## Timing
- Capture latency:
  - an_n and seg_n change before edge t and are then held.
  - an_q is valid after edge t, and the FSM enters SETTLE at t+1 with cnt=1.
  - CAPTURE occurs SETTLE−1 cycles later, and the shadow register updates at the end of that cycle.
- Publish latency: frame_valid is high exactly one cycle, one cycle after the last slot's CAPTURE cycle.
- Minimum digit dwell for a capture is SETTLE+1 clk. Shorter dwells are dropped silently.
- Asynchronous reset during any state clears everything immediately. The partial frame is discarded; no frame_valid is issued.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0, no frame_valid. Release → still 0 until the first full frame.
- Normal scan (DIGITS=4, SETTLE=4): digits 0..3 show 1,2,3,4 (1111001, 0100100, 0110000, 0011001), 8 cycles each → hex_out=16'h4321, blank_mask=0, err=0, exactly one frame_valid pulse per scan.
- Glitch rejection: digit 1 held only 3 cycles, or seg toggled mid-SETTLE → slot 1 not captured, no frame_valid. A later full-dwell rescan of digit 1 completes the frame.
- Blank and invalid: digit 3 = 1111111, digit 2 = 1010101 → blank_mask=4'b1000, err=4'b0100, nibbles 2 and 3 = 0. The frame still publishes, and err stays set until clear.
- Multi-hot and all-off: an_n=1100 or 1111 for 20 cycles → no capture, FSM stays IDLE.
- Abort: clear, or rst_n low, after 3 of 4 digits → no frame_valid. A following complete scan publishes only the new values.
